// File: rtl/mem_stage_hs.sv
// =============================================================================
// Module   : mem_stage_hs
// Purpose  : MEM pipeline stage with SRAM response handshake, load extraction,
//            forwarding and discard of responses from cancelled loads.
// Revision : 1.0
// =============================================================================
`default_nettype none

module mem_stage_hs #(
    parameter int PASS_W   = 96,
    parameter int CANCEL_W = 2
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              ex_mem_valid,
    output logic              mem_allowin,
    input  logic              ex_gr_we,
    input  logic              ex_res_from_mem,
    input  logic              ex_req_issued,
    input  logic [2:0]        ex_mem_type,
    input  logic [1:0]        ex_addr_low2,
    input  logic [4:0]        ex_dest,
    input  logic [31:0]       ex_alu_result,
    input  logic [PASS_W-1:0] ex_pass,

    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,

    input  logic              flush,

    output logic              mem_wb_valid,
    input  logic              wb_allowin,
    output logic              wb_gr_we,
    output logic [4:0]        wb_dest,
    output logic [31:0]       wb_result,
    output logic [PASS_W-1:0] wb_pass,

    output logic              fwd_valid,
    output logic [4:0]        fwd_dest,
    output logic [31:0]       fwd_result,
    output logic              fwd_pending
);

    localparam logic [CANCEL_W-1:0] DISCARD_ZERO = '0;
    localparam logic [CANCEL_W-1:0] DISCARD_ONE  = {{(CANCEL_W-1){1'b0}}, 1'b1};
    localparam logic [CANCEL_W-1:0] DISCARD_MAX  = '1;

    // mem_type[1:0] encodes the access size, mem_type[2] selects zero-extension
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Control state (reset)
    logic                mem_valid_q,   mem_valid_d;
    logic                resp_got_q,    resp_got_d;
    logic [CANCEL_W-1:0] discard_cnt_q, discard_cnt_d;

    // Payload state (no reset)
    logic                gr_we_q,        gr_we_d;
    logic                res_from_mem_q, res_from_mem_d;
    logic                req_issued_q,   req_issued_d;
    logic [2:0]          mem_type_q,     mem_type_d;
    logic [1:0]          addr_low2_q,    addr_low2_d;
    logic [4:0]          dest_q,         dest_d;
    logic [31:0]         alu_result_q,   alu_result_d;
    logic [PASS_W-1:0]   pass_q,         pass_d;
    logic [31:0]         rbuf_q,         rbuf_d;

    logic        capture;
    logic        discard_active;
    logic        resp_accept;
    logic        wait_resp;
    logic        ready_go;
    logic        discard_hit;
    logic        discard_req;
    logic [31:0] load_word;
    logic [15:0] load_half;
    logic [7:0]  load_byte;
    logic [31:0] load_ext;
    logic        load_signed;

    // Handshake: a response accepted this cycle already counts as received,
    // which gives zero-latency hand-off when WB accepts in the data_ok cycle.
    always_comb begin
        discard_active = (discard_cnt_q != DISCARD_ZERO);
        resp_accept    = data_sram_data_ok & ~discard_active & mem_valid_q
                       & req_issued_q & ~resp_got_q;
        wait_resp      = mem_valid_q & req_issued_q & ~(resp_got_q | resp_accept);
        ready_go       = ~wait_resp;
        mem_wb_valid   = mem_valid_q & ready_go;
        mem_allowin    = ~mem_valid_q | (ready_go & wb_allowin);
        capture        = ex_mem_valid & mem_allowin;
        discard_hit    = data_sram_data_ok & discard_active;
        discard_req    = flush & wait_resp;
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end

        resp_got_d = resp_got_q;
        if (flush || capture) begin
            resp_got_d = 1'b0;
        end else if (resp_accept) begin
            resp_got_d = 1'b1;
        end

        // A new cancellation and a discard in the same cycle cancel out
        discard_cnt_d = discard_cnt_q;
        if (discard_req && !discard_hit) begin
            if (discard_cnt_q != DISCARD_MAX) begin
                discard_cnt_d = discard_cnt_q + DISCARD_ONE;
            end
        end else if (!discard_req && discard_hit) begin
            discard_cnt_d = discard_cnt_q - DISCARD_ONE;
        end
    end

    always_comb begin
        gr_we_d        = gr_we_q;
        res_from_mem_d = res_from_mem_q;
        req_issued_d   = req_issued_q;
        mem_type_d     = mem_type_q;
        addr_low2_d    = addr_low2_q;
        dest_d         = dest_q;
        alu_result_d   = alu_result_q;
        pass_d         = pass_q;
        if (capture) begin
            gr_we_d        = ex_gr_we;
            res_from_mem_d = ex_res_from_mem;
            req_issued_d   = ex_req_issued;
            mem_type_d     = ex_mem_type;
            addr_low2_d    = ex_addr_low2;
            dest_d         = ex_dest;
            alu_result_d   = ex_alu_result;
            pass_d         = ex_pass;
        end
        rbuf_d = resp_accept ? data_sram_rdata : rbuf_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q   <= 1'b0;
            resp_got_q    <= 1'b0;
            discard_cnt_q <= DISCARD_ZERO;
        end else begin
            mem_valid_q   <= mem_valid_d;
            resp_got_q    <= resp_got_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        gr_we_q        <= gr_we_d;
        res_from_mem_q <= res_from_mem_d;
        req_issued_q   <= req_issued_d;
        mem_type_q     <= mem_type_d;
        addr_low2_q    <= addr_low2_d;
        dest_q         <= dest_d;
        alu_result_q   <= alu_result_d;
        pass_q         <= pass_d;
        rbuf_q         <= rbuf_d;
    end

    // Load data comes live from the SRAM in the response cycle, buffered after
    always_comb begin
        load_word   = resp_got_q ? rbuf_q : data_sram_rdata;
        load_half   = addr_low2_q[1] ? load_word[31:16] : load_word[15:0];
        load_signed = ~mem_type_q[2];
        case (addr_low2_q)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        case (mem_type_q[1:0])
            SZ_HALF: load_ext = {{16{load_signed & load_half[15]}}, load_half};
            SZ_BYTE: load_ext = {{24{load_signed & load_byte[7]}}, load_byte};
            default: load_ext = load_word;
        endcase
    end

    always_comb begin
        wb_result   = res_from_mem_q ? load_ext : alu_result_q;
        wb_gr_we    = gr_we_q;
        wb_dest     = dest_q;
        wb_pass     = pass_q;
        fwd_valid   = mem_valid_q & gr_we_q;
        fwd_dest    = dest_q;
        fwd_result  = wb_result;
        fwd_pending = fwd_valid & res_from_mem_q & wait_resp;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_hs.sv
// =============================================================================
// Module   : tb_mem_stage_hs
// Purpose  : Directed and randomized self-checking bench for mem_stage_hs.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_mem_stage_hs;

    localparam int PW = 96;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ex_mem_valid, mem_allowin;
    logic          ex_gr_we, ex_res_from_mem, ex_req_issued;
    logic [2:0]    ex_mem_type;
    logic [1:0]    ex_addr_low2;
    logic [4:0]    ex_dest;
    logic [31:0]   ex_alu_result;
    logic [PW-1:0] ex_pass;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          flush;
    logic          mem_wb_valid, wb_allowin, wb_gr_we;
    logic [4:0]    wb_dest;
    logic [31:0]   wb_result;
    logic [PW-1:0] wb_pass;
    logic          fwd_valid, fwd_pending;
    logic [4:0]    fwd_dest;
    logic [31:0]   fwd_result;

    int vectors = 0;
    int errors  = 0;

    mem_stage_hs #(.PASS_W(PW), .CANCEL_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
        .ex_gr_we(ex_gr_we), .ex_res_from_mem(ex_res_from_mem),
        .ex_req_issued(ex_req_issued), .ex_mem_type(ex_mem_type),
        .ex_addr_low2(ex_addr_low2), .ex_dest(ex_dest),
        .ex_alu_result(ex_alu_result), .ex_pass(ex_pass),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush),
        .mem_wb_valid(mem_wb_valid), .wb_allowin(wb_allowin),
        .wb_gr_we(wb_gr_we), .wb_dest(wb_dest), .wb_result(wb_result), .wb_pass(wb_pass),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
        .fwd_pending(fwd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EX and let it be captured at the next edge
    task automatic issue(input logic we, input logic res, input logic req,
                         input logic [2:0] t, input logic [1:0] lo, input logic [4:0] d,
                         input logic [31:0] alu, input logic [PW-1:0] p);
        ex_mem_valid = 1'b1;  ex_gr_we = we;  ex_res_from_mem = res;
        ex_req_issued = req;  ex_mem_type = t; ex_addr_low2 = lo;
        ex_dest = d;          ex_alu_result = alu; ex_pass = p;
        @(negedge clk);
        chk("issue_allowin", mem_allowin, 1);
        tick;
        ex_mem_valid = 1'b0;
        ex_req_issued = 1'b0;
    endtask

    task automatic load_resp(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] d,
                             input logic [31:0] exp, input string tag);
        issue(1, 1, 1, t, lo, 5'd8, 32'h0, '0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        @(negedge clk);
        chk({tag, "_valid"}, mem_wb_valid, 1);
        chk({tag, "_result"}, wb_result, exp);
        tick;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    function automatic logic [31:0] ext(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] d);
        logic [15:0] h;
        logic [7:0]  b;
        h = 16'(d >> (16 * lo[1]));
        b = 8'(d >> (8 * lo));
        case (t)
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            3'b010:  return 32'($signed(b));
            3'b110:  return {24'h0, b};
            default: return d;
        endcase
    endfunction

    typedef struct {
        logic [31:0] data;
        int          delay;
        int          id;
    } resp_t;

    resp_t rq[$];
    logic          cur_valid, cur_we, cur_res, cur_req, cur_have;
    logic [2:0]    cur_t;
    logic [1:0]    cur_lo;
    logic [4:0]    cur_d;
    logic [31:0]   cur_alu, cur_data;
    logic [PW-1:0] cur_p;
    int            cur_id, next_id;
    logic          pend, got_now, have, done, allow, cap;
    logic [31:0]   exp_res;

    initial begin
        resetn = 1'b0; ex_mem_valid = 1'b0; ex_gr_we = 1'b0; ex_res_from_mem = 1'b0;
        ex_req_issued = 1'b0; ex_mem_type = 3'b0; ex_addr_low2 = 2'b0; ex_dest = 5'b0;
        ex_alu_result = 32'b0; ex_pass = '0; data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'b0; flush = 1'b0; wb_allowin = 1'b1;

        // Reset state
        tick; tick;
        @(negedge clk);
        chk("rst_wb_valid", mem_wb_valid, 0);
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_pending", fwd_pending, 0);
        tick;
        resetn = 1'b1;

        // ld.w with response two cycles after issue
        issue(1, 1, 1, 3'b000, 2'd0, 5'd3, 32'h100, 96'hA5A5_0001);
        @(negedge clk);
        chk("ldw_wait_valid", mem_wb_valid, 0);
        chk("ldw_wait_allowin", mem_allowin, 0);
        chk("ldw_wait_pending", fwd_pending, 1);
        tick;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("ldw_ok_valid", mem_wb_valid, 1);
        chk("ldw_ok_result", wb_result, 32'h1234_5678);
        chk("ldw_ok_dest", wb_dest, 5'd3);
        chk("ldw_ok_pass", wb_pass, 96'hA5A5_0001);
        tick;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("ldw_after_valid", mem_wb_valid, 0);
        chk("ldw_after_allowin", mem_allowin, 1);
        tick;

        // Extraction
        load_resp(3'b010, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, "ldb");
        load_resp(3'b110, 2'd3, 32'h80FF_0000, 32'h0000_0080, "ldbu");
        load_resp(3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF, "ldh");
        load_resp(3'b101, 2'd0, 32'h0000_8001, 32'h0000_8001, "ldhu");
        load_resp(3'b010, 2'd1, 32'h0000_7F00, 32'h0000_007F, "ldb1");

        // WB back-pressure: data must be held after data_ok
        issue(1, 1, 1, 3'b000, 2'd0, 5'd9, 32'h0, '0);
        wb_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("bp_ok_valid", mem_wb_valid, 1);
        chk("bp_ok_allowin", mem_allowin, 0);
        tick;
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_sram_rdata = 32'h1111_1111 * (i + 1);
            @(negedge clk);
            chk("bp_hold_result", wb_result, 32'hAABB_CCDD);
            chk("bp_hold_allowin", mem_allowin, 0);
            tick;
        end
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("bp_rel_allowin", mem_allowin, 1);
        chk("bp_rel_result", wb_result, 32'hAABB_CCDD);
        tick;

        // Flush while waiting, stale then fresh response
        issue(1, 1, 1, 3'b000, 2'd0, 5'd4, 32'h0, '0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_wb_valid", mem_wb_valid, 0);
        tick;
        flush = 1'b0;
        issue(1, 1, 1, 3'b000, 2'd0, 5'd6, 32'h0, '0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
        @(negedge clk);
        chk("fl_stale_valid", mem_wb_valid, 0);
        chk("fl_stale_pending", fwd_pending, 1);
        tick;
        data_sram_rdata = 32'h0000_0042;
        @(negedge clk);
        chk("fl_fresh_valid", mem_wb_valid, 1);
        chk("fl_fresh_result", wb_result, 32'h0000_0042);
        tick;
        data_sram_data_ok = 1'b0;
        load_resp(3'b000, 2'd0, 32'h0000_0055, 32'h0000_0055, "fl_next");

        // Forwarding
        issue(1, 0, 0, 3'b000, 2'd0, 5'd5, 32'd7, '0);
        @(negedge clk);
        chk("fwd_alu_valid", fwd_valid, 1);
        chk("fwd_alu_pending", fwd_pending, 0);
        chk("fwd_alu_result", fwd_result, 32'd7);
        chk("fwd_alu_dest", fwd_dest, 5'd5);
        tick;
        issue(1, 1, 1, 3'b000, 2'd0, 5'd5, 32'h0, '0);
        @(negedge clk);
        chk("fwd_ld_valid", fwd_valid, 1);
        chk("fwd_ld_pending", fwd_pending, 1);
        tick;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'd9;
        @(negedge clk);
        chk("fwd_ld_done_pending", fwd_pending, 0);
        chk("fwd_ld_done_result", fwd_result, 32'd9);
        tick;
        data_sram_data_ok = 1'b0;

        // Reset during an outstanding load
        issue(1, 1, 1, 3'b000, 2'd0, 5'd2, 32'h0, '0);
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        @(negedge clk);
        chk("rl_wb_valid", mem_wb_valid, 0);
        chk("rl_fwd_valid", fwd_valid, 0);
        chk("rl_fwd_pending", fwd_pending, 0);
        chk("rl_allowin", mem_allowin, 1);
        tick;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0BAD;
        @(negedge clk);
        chk("rl_late_valid", mem_wb_valid, 0);
        tick;
        data_sram_data_ok = 1'b0;
        load_resp(3'b000, 2'd0, 32'h0000_0077, 32'h0000_0077, "rl_next");

        // Four cancellations saturate the discard counter at three
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 1, 3'b000, 2'd0, 5'd1, 32'h0, '0);
            flush = 1'b1;
            tick;
            flush = 1'b0;
        end
        issue(1, 1, 1, 3'b000, 2'd0, 5'd7, 32'h0, '0);
        data_sram_data_ok = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            data_sram_rdata = k;
            @(negedge clk);
            chk("sat_discard_valid", mem_wb_valid, 0);
            tick;
        end
        data_sram_rdata = 32'd4;
        @(negedge clk);
        chk("sat_accept_valid", mem_wb_valid, 1);
        chk("sat_accept_result", wb_result, 32'd4);
        tick;
        data_sram_data_ok = 1'b0;

        // Randomized traffic against a transaction-level model
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        rq.delete();
        cur_valid = 1'b0; cur_have = 1'b0; cur_id = -1; next_id = 0; pend = 1'b0;
        cur_we = 1'b0; cur_res = 1'b0; cur_req = 1'b0; cur_t = 3'b0; cur_lo = 2'b0;
        cur_d = 5'b0; cur_alu = 32'b0; cur_data = 32'b0; cur_p = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pend) begin
                ex_mem_valid = 1'b0;
                ex_req_issued = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    ex_gr_we        = (kind != 2);
                    ex_res_from_mem = (kind == 1);
                    ex_req_issued   = (kind != 0);
                    case ($urandom_range(0, 4))
                        0: ex_mem_type = 3'b000;
                        1: ex_mem_type = 3'b001;
                        2: ex_mem_type = 3'b010;
                        3: ex_mem_type = 3'b101;
                        default: ex_mem_type = 3'b110;
                    endcase
                    ex_addr_low2  = 2'($urandom);
                    ex_dest       = 5'($urandom);
                    ex_alu_result = $urandom;
                    ex_pass       = {$urandom, $urandom, $urandom};
                    ex_mem_valid  = 1'b1;
                    pend          = 1'b1;
                end
            end
            if (rq.size() > 0 && rq[0].delay == 0) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = rq[0].data;
            end else begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
            end
            wb_allowin = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0) && (rq.size() < 3)
                    && !(ex_mem_valid && ex_req_issued);

            @(negedge clk);
            got_now = data_sram_data_ok && cur_valid && (rq[0].id == cur_id);
            have    = cur_have || got_now;
            done    = cur_valid && (!cur_req || have);
            allow   = !cur_valid || (done && wb_allowin);
            exp_res = cur_res ? ext(cur_t, cur_lo, cur_have ? cur_data : data_sram_rdata) : cur_alu;
            chk("rnd_wb_valid", mem_wb_valid, done);
            chk("rnd_allowin", mem_allowin, allow);
            chk("rnd_fwd_valid", fwd_valid, cur_valid && cur_we);
            chk("rnd_fwd_pending", fwd_pending, cur_valid && cur_we && cur_res && cur_req && !have);
            if (done) begin
                chk("rnd_wb_result", wb_result, exp_res);
                chk("rnd_wb_dest", wb_dest, cur_d);
                chk("rnd_wb_gr_we", wb_gr_we, cur_we);
                chk("rnd_wb_pass", wb_pass, cur_p);
                if (cur_we) chk("rnd_fwd_result", fwd_result, exp_res);
            end

            if (got_now) begin
                cur_have = 1'b1;
                cur_data = data_sram_rdata;
            end
            if (data_sram_data_ok) void'(rq.pop_front());
            else if (rq.size() > 0) rq[0].delay--;
            cap = pend && allow;
            if (cap && ex_req_issued) begin
                resp_t r;
                r.data  = $urandom;
                r.delay = $urandom_range(0, 3);
                r.id    = next_id;
                rq.push_back(r);
            end
            if (flush) begin
                cur_valid = 1'b0;
            end else if (allow) begin
                cur_valid = cap;
                if (cap) begin
                    cur_we = ex_gr_we; cur_res = ex_res_from_mem; cur_req = ex_req_issued;
                    cur_t = ex_mem_type; cur_lo = ex_addr_low2; cur_d = ex_dest;
                    cur_alu = ex_alu_result; cur_p = ex_pass; cur_id = next_id;
                    cur_have = 1'b0;
                end
            end
            if (cap) begin
                next_id++;
                pend = 1'b0;
            end
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
